// File: rtl/cordic_ctrl.sv
// Sequencer for an iterative CORDIC datapath: load strobe, NITER enable cycles, ready strobe.
// Latency: start sampled at edge k -> load in cycle k+1, enable k+2..k+NITER+1, ready k+NITER+2.
// No backpressure: start is only looked at in IDLE and is never queued; abort cancels at once.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   start    - request a new operation (sampled in IDLE only)
//   abort    - synchronous cancel of the operation in progress
//   load     - one-cycle strobe: datapath loads initial x/y/z
//   enable   - datapath performs one micro-rotation this cycle
//   rom_addr - arctangent table address, equals iteration index i
//   busy     - high from the LOAD cycle through the DONE cycle
//   ready    - one-cycle strobe: datapath results are valid
module cordic_ctrl #(
    parameter int NITER = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       load,
    output logic       enable,
    output logic [5:0] rom_addr,
    output logic       busy,
    output logic       ready
);

    generate
        if ((NITER < 1) || (NITER > 32)) begin : g_niter_check
            $error("cordic_ctrl: NITER=%0d outside legal range 1..32", NITER);
        end
    endgenerate

    // Index of the final micro-rotation; i never counts past it, so a
    // 5-bit counter covers NITER=32 without wrapping.
    localparam logic [4:0] LAST = 5'(NITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] i;
    logic [4:0] i_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= 5'd0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
        end
    end

    // Outputs are decoded from state and i only, so an asynchronous reset
    // forces them to zero immediately without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        load      = 1'b0;
        enable    = 1'b0;
        busy      = 1'b0;
        ready     = 1'b0;
        rom_addr  = 6'd0;

        case (state)
            IDLE: begin
                i_nxt = 5'd0;
                if (start && !abort) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                load  = 1'b1;
                busy  = 1'b1;
                i_nxt = 5'd0;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ITER;
                end
            end

            ITER: begin
                enable   = 1'b1;
                busy     = 1'b1;
                rom_addr = {1'b0, i};
                if (abort) begin
                    state_nxt = IDLE;
                    i_nxt     = 5'd0;
                end else if (i == LAST) begin
                    state_nxt = DONE;
                    i_nxt     = 5'd0;
                end else begin
                    i_nxt = i + 5'd1;
                end
            end

            DONE: begin
                ready     = 1'b1;
                busy      = 1'b1;
                i_nxt     = 5'd0;
                // Whether or not abort is high, DONE lasts one cycle and
                // returns to IDLE; start is not honoured here.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                i_nxt     = 5'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_ctrl.sv
module tb_cordic_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [2:0] abort;
    logic [2:0] load;
    logic [2:0] enable;
    logic [2:0] busy;
    logic [2:0] ready;
    logic [5:0] ra0, ra1, ra2;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    always #5 clock = ~clock;
    always @(posedge clock) ecount++;

    cordic_ctrl #(.NITER(32)) u32 (
        .clock(clock), .reset(reset), .start(start[0]), .abort(abort[0]),
        .load(load[0]), .enable(enable[0]), .rom_addr(ra0), .busy(busy[0]), .ready(ready[0])
    );
    cordic_ctrl #(.NITER(1)) u1 (
        .clock(clock), .reset(reset), .start(start[1]), .abort(abort[1]),
        .load(load[1]), .enable(enable[1]), .rom_addr(ra1), .busy(busy[1]), .ready(ready[1])
    );
    cordic_ctrl #(.NITER(4)) u4 (
        .clock(clock), .reset(reset), .start(start[2]), .abort(abort[2]),
        .load(load[2]), .enable(enable[2]), .rom_addr(ra2), .busy(busy[2]), .ready(ready[2])
    );

    // Expected non-idle cycle: cycle label = (edges so far)+1, i.e. the
    // cycle that follows edge k is cycle k+1.
    typedef struct {
        int         cyc;
        logic       ld;
        logic       en;
        logic       bz;
        logic       rd;
        logic [5:0] ad;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int d);
        case (d)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int d);
        case (d)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int d, input exp_t x);
        case (d)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endfunction

    // Push the expected trace of one operation whose start is sampled at
    // edge e: load, then keep enable cycles, then ready if not cut short.
    task automatic issue(input int d, input int n, input int keep, input int e);
        exp_t x;
        x = '{cyc: e + 1, ld: 1'b1, en: 1'b0, bz: 1'b1, rd: 1'b0, ad: 6'd0};
        qpush(d, x);
        for (int j = 0; j < keep; j++) begin
            x = '{cyc: e + 2 + j, ld: 1'b0, en: 1'b1, bz: 1'b1, rd: 1'b0, ad: 6'(j)};
            qpush(d, x);
        end
        if (keep == n) begin
            x = '{cyc: e + n + 2, ld: 1'b0, en: 1'b0, bz: 1'b1, rd: 1'b1, ad: 6'd0};
            qpush(d, x);
        end
    endtask

    task automatic mon(input int d, input logic ld, input logic en, input logic bz,
                       input logic rd, input logic [5:0] ad);
        int   lab;
        bit   act;
        bit   due;
        exp_t x;
        lab = ecount + 1;
        act = ld | en | bz | rd | (ad != 6'd0);
        due = (qsize(d) > 0) && (qfront(d).cyc == lab);
        if (act || due) begin
            checks++;
            if (qsize(d) == 0) begin
                errors++;
                $display("FAIL mon%0d unexpected output at cycle %0d: ld=%b en=%b bz=%b rd=%b ad=%0d, required idle",
                         d, lab, ld, en, bz, rd, ad);
            end else begin
                x = qfront(d);
                qpop(d);
                if (x.cyc != lab || x.ld != ld || x.en != en || x.bz != bz || x.rd != rd || x.ad != ad) begin
                    errors++;
                    $display("FAIL mon%0d: got cyc=%0d ld=%b en=%b bz=%b rd=%b ad=%0d, required cyc=%0d ld=%b en=%b bz=%b rd=%b ad=%0d",
                             d, lab, ld, en, bz, rd, ad, x.cyc, x.ld, x.en, x.bz, x.rd, x.ad);
                end
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, load[0], enable[0], busy[0], ready[0], ra0);
        mon(1, load[1], enable[1], busy[1], ready[1], ra1);
        mon(2, load[2], enable[2], busy[2], ready[2], ra2);
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_u32"}, int'({load[0], enable[0], busy[0], ready[0], ra0}), 0);
        chk({nm, "_u1"},  int'({load[1], enable[1], busy[1], ready[1], ra1}), 0);
        chk({nm, "_u4"},  int'({load[2], enable[2], busy[2], ready[2], ra2}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1;
        start = 3'b000;
        abort = 3'b000;
        #2;
        chk_idle("reset_state");
        repeat (3) @(negedge clock);

        // NITER=1, start accepted on the first edge after reset release
        start[1] = 1'b1;
        issue(1, 1, 1, ecount + 1);
        reset = 1'b0;
        @(negedge clock);
        start[1] = 1'b0;
        repeat (6) @(negedge clock);

        // Nominal 32-iteration run
        start[0] = 1'b1;
        issue(0, 32, 32, ecount + 1);
        @(negedge clock);
        start[0] = 1'b0;
        repeat (40) @(negedge clock);

        // Extra start pulse during ITER must be ignored
        start[0] = 1'b1;
        issue(0, 32, 32, ecount + 1);
        @(negedge clock);
        start[0] = 1'b0;
        repeat (9) @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        repeat (40) @(negedge clock);

        // Abort while i=7
        start[0] = 1'b1;
        e = ecount + 1;
        issue(0, 32, 8, e);
        @(negedge clock);
        start[0] = 1'b0;
        repeat (8) @(negedge clock);
        chk("abort_at_i7_addr", int'(ra0), 7);
        abort[0] = 1'b1;
        @(negedge clock);
        abort[0] = 1'b0;
        chk("abort_idle_load", int'(load[0]), 0);
        chk("abort_idle_enable", int'(enable[0]), 0);
        chk("abort_idle_busy", int'(busy[0]), 0);
        chk("abort_idle_ready", int'(ready[0]), 0);
        chk("abort_idle_addr", int'(ra0), 0);
        repeat (45) @(negedge clock);
        start[0] = 1'b1;
        issue(0, 32, 32, ecount + 1);
        @(negedge clock);
        start[0] = 1'b0;
        repeat (40) @(negedge clock);

        // Asynchronous reset between edges while i=15
        start[0] = 1'b1;
        e = ecount + 1;
        issue(0, 32, 16, e);
        @(negedge clock);
        start[0] = 1'b0;
        repeat (16) @(negedge clock);
        chk("pre_reset_addr", int'(ra0), 15);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);

        // NITER=4 with start held high: ops sampled every 7 edges
        start[2] = 1'b1;
        e = ecount + 1;
        issue(2, 4, 4, e);
        issue(2, 4, 4, e + 7);
        issue(2, 4, 4, e + 14);
        repeat (16) @(negedge clock);
        start[2] = 1'b0;
        repeat (30) @(negedge clock);

        chk("q_empty_u32", q0.size(), 0);
        chk("q_empty_u1", q1.size(), 0);
        chk("q_empty_u4", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 SHALL have parameter NITER, default 32, number of CORDIC micro-rotations per operation; legal range 1..32.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the operation in progress.
REQ-006 SHALL have port load  output  1  one-cycle strobe telling the datapath to load initial x/y/z.
REQ-007 SHALL have port enable  output  1  datapath performs one micro-rotation in each cycle this is high.
REQ-008 SHALL have port rom_addr  output  6  arctangent lookup-table address; equals the current iteration index i.
REQ-009 SHALL have port busy  output  1  high from the LOAD cycle through the DONE cycle inclusive.
REQ-010 SHALL have port ready  output  1  one-cycle strobe marking valid datapath results.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, ITER, DONE, all outputs registered or decoded solely from state and counter (Moore).
REQ-012 SHALL transition IDLE->LOAD on a rising edge where start=1 and abort=0; otherwise remain in IDLE.
REQ-013 SHALL spend exactly one cycle in LOAD with load=1, enable=0, rom_addr=0, then enter ITER with counter i=0.
REQ-014 SHALL in ITER drive enable=1 and rom_addr={1'b0,i[4:0]} and increment i by 1 each cycle.
REQ-015 SHALL leave ITER after the cycle with i=NITER-1, entering DONE; exactly NITER enable cycles per operation.
REQ-016 SHALL spend exactly one cycle in DONE with ready=1, enable=0, then return to IDLE.
REQ-017 SHALL give fixed latency: start sampled at edge k -> load high in cycle k+1, enable high cycles k+2..k+NITER+1, ready high in cycle k+NITER+2.
REQ-018 SHALL ignore start in LOAD, ITER and DONE (no queuing); start held high continuously SHALL begin a new operation in the cycle after returning to IDLE.
REQ-019 SHALL on abort=1 in LOAD, ITER or DONE go to IDLE on the next edge, clear i, and not assert ready for that operation; abort has priority over start and over normal transitions.
REQ-020 SHALL in IDLE drive load=0, enable=0, busy=0, ready=0, rom_addr=0.
REQ-021 SHALL never let rom_addr exceed NITER-1; counter width 5 bits with no wrap-around inside one operation.
REQ-022 SHALL reject NITER outside 1..32 at elaboration (simulation $error or equivalent).

Reset
REQ-023 SHALL on reset=1 immediately (without a clock edge) force state IDLE, i=0, load=0, enable=0, busy=0, ready=0, rom_addr=0.
REQ-024 SHALL on reset asserted mid-operation discard the operation; after release, no ready SHALL appear without a new start.
REQ-025 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-026 SHALL verify nominal run, NITER=32: start pulse at edge 10 -> load in cycle 11, enable cycles 12..43 with rom_addr 0..31, ready in cycle 44, busy cycles 11..44.
REQ-027 SHALL verify NITER=1: start at edge 5 -> load cycle 6, one enable cycle 7 rom_addr=0, ready cycle 8.
REQ-028 SHALL verify start pulses during ITER (NITER=32, extra start at cycle 20) -> ignored, single ready at cycle 44, no second load.
REQ-029 SHALL verify abort at ITER i=7 -> IDLE next cycle, enable/busy low, rom_addr=0, no ready; subsequent start gives a full 32-iteration run.
REQ-030 SHALL verify asynchronous reset asserted between edges at i=15 -> outputs zero before next edge; after release no ready until new start.
REQ-031 SHALL verify start held high continuously (NITER=4) -> back-to-back operations, ready every 7 cycles, one IDLE cycle between DONE and next LOAD.
